parking_gate_ctrl: RTL and testbench
====================================

Name: parking_gate_ctrl

Overview:
- Upstream front-end of the parking occupancy counter. Turns raw entry/exit loop sensors and the badge reader into clean, class-tagged car_entered/car_exited pulses.
- Drives both barriers. Admits a car only when the downstream counter reports space for that car's class.
- Never pulses entry and exit in the same cycle, so the downstream counters are never updated twice at once.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to accept a loop level change (range 1..255).
- BADGE_TIMEOUT, 16, cycles in E_WAIT_BADGE with no badge before the car is classed as visitor (range 1..65535).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- entry_loop  in  1  raw entry vehicle-presence loop, asynchronous
- entry_badge_valid  in  1  one-cycle strobe from badge reader, synchronous to clk
- entry_badge_uni  in  1  badge class, valid with entry_badge_valid (1 = university)
- exit_loop  in  1  raw exit vehicle-presence loop, asynchronous
- exit_badge_uni  in  1  exit-lane class level, synchronous to clk, sampled on accepted exit-loop rise
- uni_space_avail  in  1  downstream: university space free
- space_avail  in  1  downstream: public space free
- entry_barrier_open  out  1  entry barrier command
- exit_barrier_open  out  1  exit barrier command
- car_entered  out  1  one-cycle pulse per admitted car
- is_uni_car_entered  out  1  class of entering car
- car_exited  out  1  one-cycle pulse per departed car
- is_uni_car_exited  out  1  class of exiting car
- entry_rejected  out  1  one-cycle pulse when entry refused for lack of space

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0.
  - FSMs to E_IDLE / X_IDLE; debounced levels 0; counters 0; exit_pending 0.
  - Reset mid-operation aborts any gate sequence and emits no pulse.
- Loop conditioning, identical per loop:
  - 2-flop synchronizer, then a debouncer with an 8-bit counter.
  - The debounced level changes after DEBOUNCE_CYCLES consecutive synchronized samples that differ from it. Any agreeing sample clears the counter.
  - Raw edge to debounced edge latency: 2 + DEBOUNCE_CYCLES cycles.
- Entry FSM:
  - E_IDLE: debounced entry_loop rise -> E_WAIT_BADGE, timer = 0.
  - E_WAIT_BADGE:
    - entry_badge_valid sets class = entry_badge_uni.
    - If instead timer reaches BADGE_TIMEOUT-1 with no badge, class = 0.
    - Same cycle as the class decision:
      - avail = class ? uni_space_avail : space_avail.
      - avail = 1 -> E_OPEN, is_uni_car_entered <= class.
      - avail = 0 -> entry_rejected pulse -> E_HOLD.
    - Badge strobe wins over a same-cycle timeout.
    - Debounced loop fall while waiting -> E_IDLE, no event.
  - E_OPEN: entry_barrier_open = 1 (registered, asserted the cycle after entering E_OPEN). Debounced loop fall -> car_entered pulse next cycle -> E_IDLE, barrier 0.
  - E_HOLD: barrier closed; debounced loop fall -> E_IDLE.
  - Badge strobes outside E_WAIT_BADGE are ignored.
- Exit FSM:
  - X_IDLE: debounced exit_loop rise -> is_uni_car_exited <= exit_badge_uni -> X_OPEN.
  - X_OPEN: exit_barrier_open = 1. Debounced loop fall -> request exit pulse -> X_IDLE.
  - Exit is never refused.
- Event arbitration:
  - car_entered and car_exited are never high in the same cycle.
  - Both requested in the same cycle -> car_entered first; exit held in exit_pending; car_exited pulses the following cycle.
  - exit_pending is 1 deep; a new exit cannot arrive within that window because exit takes ≥ DEBOUNCE_CYCLES to re-arm.
- Class outputs:
  - is_uni_* are registered and change only at the FSM class latch.
  - They are therefore stable ≥1 cycle before and during their pulse, and hold their value afterwards.
- Space inputs are sampled only at the decision cycle. Later changes do not close an open barrier.
- Counter widths: timer 16 bits, saturating.

Test Plan:
- Clean entry: entry_loop rises at t0, entry_badge_valid=1 with entry_badge_uni=1 at t0+10, uni_space_avail=1 -> entry_barrier_open=1 at t0+11. Loop falls at t1 -> car_entered single-cycle pulse at t1+7 (DEBOUNCE=4), is_uni_car_entered=1.
- Full lot: space_avail=0, entry_loop high, no badge -> after BADGE_TIMEOUT=16 cycles, entry_rejected pulse once; barrier stays 0. Loop fall -> E_IDLE; no car_entered.
- Glitch rejection: entry_loop high for 3 cycles only -> no FSM transition and no outputs. A 6-cycle high -> E_WAIT_BADGE.
- Simultaneous events: entry and exit loop falls debounced in the same cycle -> car_entered at cycle N, car_exited at N+1, never both high.
- Exit class: exit_badge_uni=0 at exit_loop rise, then switched to 1 -> car_exited pulse carries is_uni_car_exited=0.
- Reset in E_OPEN: rst_n low for 1 cycle while barrier open -> all outputs 0 immediately. Following loop fall produces no car_entered.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// Parking gate front-end: conditions the entry/exit loop sensors, runs both barrier
// FSMs and serialises class-tagged car_entered / car_exited pulses for the counter.
module parking_gate_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned BADGE_TIMEOUT   = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic entry_loop,
   input  logic entry_badge_valid,
   input  logic entry_badge_uni,
   input  logic exit_loop,
   input  logic exit_badge_uni,
   input  logic uni_space_avail,
   input  logic space_avail,
   output logic entry_barrier_open,
   output logic exit_barrier_open,
   output logic car_entered,
   output logic is_uni_car_entered,
   output logic car_exited,
   output logic is_uni_car_exited,
   output logic entry_rejected
);

   localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES - 32'd1);
   localparam logic [15:0] TMO_LAST = 16'(BADGE_TIMEOUT - 32'd1);

   typedef enum logic [1:0] {
      E_IDLE       = 2'd0,
      E_WAIT_BADGE = 2'd1,
      E_OPEN       = 2'd2,
      E_HOLD       = 2'd3
   } entry_state_t;

   typedef enum logic {
      X_IDLE = 1'b0,
      X_OPEN = 1'b1
   } exit_state_t;

   entry_state_t e_state_r;
   exit_state_t  x_state_r;

   // Bit 0 is the entry loop, bit 1 the exit loop.
   logic [1:0]  raw_s;
   logic [1:0]  sync1_r;
   logic [1:0]  sync2_r;
   logic [1:0]  deb_r;
   logic [1:0]  deb_d_r;
   logic [7:0]  deb_cnt_r [2];
   logic [15:0] timer_r;
   logic        exit_pending_r;

   logic e_rise_s;
   logic x_rise_s;
   logic entry_req_s;
   logic exit_req_s;
   logic decide_s;
   logic class_s;
   logic avail_s;

   assign raw_s = {exit_loop, entry_loop};

   // Debounced edge decode, event requests and the entry admission decision.
   always_comb begin
      e_rise_s    = deb_r[0] & ~deb_d_r[0];
      x_rise_s    = deb_r[1] & ~deb_d_r[1];
      entry_req_s = (e_state_r == E_OPEN) & ~deb_r[0];
      exit_req_s  = (x_state_r == X_OPEN) & ~deb_r[1];
      decide_s    = entry_badge_valid | (timer_r == TMO_LAST);
      if (entry_badge_valid) begin
         class_s = entry_badge_uni;
      end else begin
         class_s = 1'b0;
      end
      if (class_s) begin
         avail_s = uni_space_avail;
      end else begin
         avail_s = space_avail;
      end
   end

   // Two-flop synchronisers and run-length debouncers for both loops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 2'b00;
         sync2_r <= 2'b00;
         deb_r   <= 2'b00;
         deb_d_r <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            deb_cnt_r[i] <= 8'd0;
         end
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
         deb_d_r <= deb_r;
         for (int i = 0; i < 2; i++) begin
            if (sync2_r[i] != deb_r[i]) begin
               if (deb_cnt_r[i] == DEB_LAST) begin
                  deb_r[i]     <= sync2_r[i];
                  deb_cnt_r[i] <= 8'd0;
               end else begin
                  deb_cnt_r[i] <= deb_cnt_r[i] + 8'd1;
               end
            end else begin
               deb_cnt_r[i] <= 8'd0;
            end
         end
      end
   end

   // Entry FSM: badge/timeout classification, space check and entry pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_state_r          <= E_IDLE;
         timer_r            <= 16'd0;
         entry_barrier_open <= 1'b0;
         car_entered        <= 1'b0;
         is_uni_car_entered <= 1'b0;
         entry_rejected     <= 1'b0;
      end else begin
         car_entered        <= entry_req_s;
         entry_rejected     <= 1'b0;
         entry_barrier_open <= (e_state_r == E_OPEN);
         case (e_state_r)
            E_IDLE: begin
               if (e_rise_s) begin
                  e_state_r <= E_WAIT_BADGE;
                  timer_r   <= 16'd0;
               end
            end
            E_WAIT_BADGE: begin
               // A car backing out before classification produces no event.
               if (!deb_r[0]) begin
                  e_state_r <= E_IDLE;
               end else if (decide_s) begin
                  if (avail_s) begin
                     e_state_r          <= E_OPEN;
                     is_uni_car_entered <= class_s;
                  end else begin
                     e_state_r      <= E_HOLD;
                     entry_rejected <= 1'b1;
                  end
               end else if (timer_r != 16'hFFFF) begin
                  timer_r <= timer_r + 16'd1;
               end
            end
            E_OPEN, E_HOLD: begin
               if (!deb_r[0]) begin
                  e_state_r <= E_IDLE;
               end
            end
            default: begin
               e_state_r <= E_IDLE;
            end
         endcase
      end
   end

   // Exit FSM plus arbitration: entry wins a tie, exit is replayed one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_state_r         <= X_IDLE;
         exit_barrier_open <= 1'b0;
         is_uni_car_exited <= 1'b0;
         car_exited        <= 1'b0;
         exit_pending_r    <= 1'b0;
      end else begin
         exit_barrier_open <= (x_state_r == X_OPEN);
         exit_pending_r    <= exit_req_s & entry_req_s;
         car_exited        <= exit_pending_r | (exit_req_s & ~entry_req_s);
         case (x_state_r)
            X_IDLE: begin
               if (x_rise_s) begin
                  x_state_r         <= X_OPEN;
                  is_uni_car_exited <= exit_badge_uni;
               end
            end
            X_OPEN: begin
               if (!deb_r[1]) begin
                  x_state_r <= X_IDLE;
               end
            end
            default: begin
               x_state_r <= X_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_parking_gate_ctrl;

   localparam int DEB = 4;
   localparam int BT  = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic entry_loop = 1'b0;
   logic entry_badge_valid = 1'b0;
   logic entry_badge_uni = 1'b0;
   logic exit_loop = 1'b0;
   logic exit_badge_uni = 1'b0;
   logic uni_space_avail = 1'b0;
   logic space_avail = 1'b0;
   logic entry_barrier_open, exit_barrier_open, car_entered, is_uni_car_entered;
   logic car_exited, is_uni_car_exited, entry_rejected;
   logic [6:0] outs;

   parking_gate_ctrl #(.DEBOUNCE_CYCLES(DEB), .BADGE_TIMEOUT(BT)) dut (
      .clk(clk), .rst_n(rst_n),
      .entry_loop(entry_loop), .entry_badge_valid(entry_badge_valid),
      .entry_badge_uni(entry_badge_uni), .exit_loop(exit_loop),
      .exit_badge_uni(exit_badge_uni), .uni_space_avail(uni_space_avail),
      .space_avail(space_avail), .entry_barrier_open(entry_barrier_open),
      .exit_barrier_open(exit_barrier_open), .car_entered(car_entered),
      .is_uni_car_entered(is_uni_car_entered), .car_exited(car_exited),
      .is_uni_car_exited(is_uni_car_exited), .entry_rejected(entry_rejected)
   );

   always #5 clk = ~clk;

   assign outs = {entry_barrier_open, exit_barrier_open, car_entered, is_uni_car_entered,
                  car_exited, is_uni_car_exited, entry_rejected};

   int vectors = 0;
   int miscompares = 0;

   // Model state: raw sample histories, debounced levels, lane phases, event queue.
   bit m_eq[$];
   bit m_xq[$];
   bit m_edeb, m_edeb_old, m_xdeb, m_xdeb_old, m_xopen;
   int m_ephase;   // 0 idle, 1 waiting for badge, 2 barrier open, 3 refused
   int m_wait_n;
   int ev_q[$];    // 1 = entered, 2 = exited
   bit x_ebar, x_xbar, x_ce, x_iuce, x_cx, x_iucx, x_rej;

   int rej_at, rej_n, cnt, e_hold, x_hold;
   bit seen;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit window_is(input bit q[$], input bit v);
      for (int i = 2; i < DEB + 2; i++) begin
         if (q[i] != v) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_eq.delete();
      m_xq.delete();
      for (int i = 0; i < DEB + 2; i++) begin
         m_eq.push_back(1'b0);
         m_xq.push_back(1'b0);
      end
      m_edeb = 0; m_edeb_old = 0; m_xdeb = 0; m_xdeb_old = 0; m_xopen = 0;
      m_ephase = 0; m_wait_n = 0;
      ev_q.delete();
      x_ebar = 0; x_xbar = 0; x_ce = 0; x_iuce = 0; x_cx = 0; x_iucx = 0; x_rej = 0;
   endtask

   // Advance the model across one clock edge using the inputs currently applied.
   task automatic model_step();
      bit ent_req, ex_req, cls, ok;
      int ev;
      if (!rst_n) begin
         model_reset();
         return;
      end
      ent_req = (m_ephase == 2) && !m_edeb;
      ex_req  = m_xopen && !m_xdeb;
      x_ebar  = (m_ephase == 2);
      x_xbar  = m_xopen;
      x_rej   = 1'b0;
      case (m_ephase)
         0: if (m_edeb && !m_edeb_old) begin m_ephase = 1; m_wait_n = 0; end
         1: begin
            if (!m_edeb) m_ephase = 0;
            else begin
               m_wait_n++;
               if (entry_badge_valid || m_wait_n == BT) begin
                  cls = entry_badge_valid ? entry_badge_uni : 1'b0;
                  ok  = cls ? uni_space_avail : space_avail;
                  if (ok) begin m_ephase = 2; x_iuce = cls; end
                  else begin m_ephase = 3; x_rej = 1'b1; end
               end
            end
         end
         default: if (!m_edeb) m_ephase = 0;
      endcase
      if (!m_xopen && m_xdeb && !m_xdeb_old) begin
         m_xopen = 1'b1;
         x_iucx  = exit_badge_uni;
      end else if (m_xopen && !m_xdeb) begin
         m_xopen = 1'b0;
      end
      if (ent_req) ev_q.push_back(1);
      if (ex_req) ev_q.push_back(2);
      x_ce = 1'b0;
      x_cx = 1'b0;
      if (ev_q.size() > 0) begin
         ev = ev_q.pop_front();
         if (ev == 1) x_ce = 1'b1; else x_cx = 1'b1;
      end
      // A level is accepted once DEB consecutive synchronised samples disagree with it.
      m_eq.push_front(entry_loop); void'(m_eq.pop_back());
      m_xq.push_front(exit_loop);  void'(m_xq.pop_back());
      m_edeb_old = m_edeb;
      m_xdeb_old = m_xdeb;
      if (window_is(m_eq, !m_edeb)) m_edeb = !m_edeb;
      if (window_is(m_xq, !m_xdeb)) m_xdeb = !m_xdeb;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check("outputs[ebar,xbar,ce,iuce,cx,iucx,rej]", {1'b0, outs},
            {1'b0, x_ebar, x_xbar, x_ce, x_iuce, x_cx, x_iucx, x_rej});
      check("no_double_pulse", {7'd0, car_entered & car_exited}, 8'd0);
   endtask

   function automatic int new_hold();
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, 3));
      return int'($urandom_range(6, 40));
   endfunction

   initial begin
      model_reset();
      @(negedge clk);
      tick(); tick();
      check("reset_outputs", {1'b0, outs}, 8'd0);
      rst_n = 1'b1;

      // Clean university entry.
      uni_space_avail = 1'b1; space_avail = 1'b0; entry_loop = 1'b1;
      repeat (9) tick();
      entry_badge_valid = 1'b1; entry_badge_uni = 1'b1;
      tick();
      entry_badge_valid = 1'b0; entry_badge_uni = 1'b0;
      check("entry_barrier_t0+10", {7'd0, entry_barrier_open}, 8'd0);
      tick();
      check("entry_barrier_t0+11", {7'd0, entry_barrier_open}, 8'd1);
      check("entry_class_uni", {7'd0, is_uni_car_entered}, 8'd1);
      repeat (4) tick();
      entry_loop = 1'b0;
      repeat (6) tick();
      check("car_entered_t1+6", {7'd0, car_entered}, 8'd0);
      tick();
      check("car_entered_t1+7", {7'd0, car_entered}, 8'd1);
      check("car_entered_class", {7'd0, is_uni_car_entered}, 8'd1);
      tick();
      check("car_entered_single", {7'd0, car_entered}, 8'd0);
      repeat (4) tick();

      // Full lot: visitor times out and is refused exactly once.
      uni_space_avail = 1'b0; entry_loop = 1'b1;
      rej_at = -1; rej_n = 0; seen = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (entry_rejected) begin
            rej_n++;
            if (rej_at < 0) rej_at = c;
         end
         if (entry_barrier_open) seen = 1'b1;
      end
      check("reject_cycle", 8'(rej_at), 8'd23);
      check("reject_count", 8'(rej_n), 8'd1);
      check("reject_barrier_closed", {7'd0, seen}, 8'd0);
      entry_loop = 1'b0; cnt = 0;
      repeat (10) begin tick(); cnt += int'(car_entered); end
      check("no_entry_after_reject", 8'(cnt), 8'd0);

      // Glitch rejection, then a 6-cycle pulse that is accepted.
      space_avail = 1'b1; entry_loop = 1'b1;
      repeat (3) tick();
      entry_loop = 1'b0; cnt = 0;
      repeat (20) begin
         tick();
         cnt += int'(entry_barrier_open | entry_rejected | car_entered);
      end
      check("glitch_ignored", 8'(cnt), 8'd0);
      entry_loop = 1'b1;
      repeat (6) tick();
      entry_loop = 1'b0;
      tick(); tick();
      entry_badge_valid = 1'b1; entry_badge_uni = 1'b0;
      tick();
      entry_badge_valid = 1'b0;
      tick();
      check("six_cycle_accepted", {7'd0, entry_barrier_open}, 8'd1);
      repeat (8) tick();

      // Simultaneous entry and exit completion.
      uni_space_avail = 1'b1; entry_loop = 1'b1; exit_loop = 1'b1; exit_badge_uni = 1'b1;
      repeat (8) tick();
      entry_badge_valid = 1'b1; entry_badge_uni = 1'b1;
      tick();
      entry_badge_valid = 1'b0; entry_badge_uni = 1'b0;
      repeat (5) tick();
      entry_loop = 1'b0; exit_loop = 1'b0;
      repeat (6) tick();
      tick();
      check("sim_entered_N", {6'd0, car_entered, car_exited}, 8'b10);
      tick();
      check("sim_exited_N+1", {6'd0, car_entered, car_exited}, 8'b01);
      check("sim_exit_class", {7'd0, is_uni_car_exited}, 8'd1);
      tick();
      check("sim_done", {6'd0, car_entered, car_exited}, 8'b00);
      repeat (3) tick();

      // Exit class is latched at the accepted rise only.
      exit_badge_uni = 1'b0; exit_loop = 1'b1;
      repeat (7) tick();
      exit_badge_uni = 1'b1;
      repeat (5) tick();
      exit_loop = 1'b0;
      repeat (7) tick();
      check("exit_pulse", {7'd0, car_exited}, 8'd1);
      check("exit_class_latched", {7'd0, is_uni_car_exited}, 8'd0);
      repeat (3) tick();

      // Reset while the entry barrier is open.
      space_avail = 1'b1; entry_loop = 1'b1;
      repeat (8) tick();
      entry_badge_valid = 1'b1;
      tick();
      entry_badge_valid = 1'b0;
      repeat (3) tick();
      check("open_before_reset", {7'd0, entry_barrier_open}, 8'd1);
      rst_n = 1'b0;
      #1;
      check("reset_immediate", {1'b0, outs}, 8'd0);
      tick();
      entry_loop = 1'b0; rst_n = 1'b1; cnt = 0;
      repeat (20) begin tick(); cnt += int'(car_entered); end
      check("no_entry_after_reset", 8'(cnt), 8'd0);

      // Randomized traffic.
      e_hold = new_hold(); x_hold = new_hold();
      for (int c = 0; c < 4000; c++) begin
         rst_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
         e_hold--;
         if (e_hold <= 0) begin entry_loop = ~entry_loop; e_hold = new_hold(); end
         x_hold--;
         if (x_hold <= 0) begin exit_loop = ~exit_loop; x_hold = new_hold(); end
         entry_badge_valid = ($urandom_range(0, 9) == 0);
         entry_badge_uni   = 1'($urandom_range(0, 1));
         exit_badge_uni    = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) space_avail = ~space_avail;
         if ($urandom_range(0, 7) == 0) uni_space_avail = ~uni_space_avail;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
